kyber_rej_uniform_sampler: RTL
==============================

# kyber_rej_uniform_sampler

Streaming rejection sampler that turns SHAKE128 output into uniform coefficients mod KYBER_Q for one polynomial of the public matrix A. It takes multi-byte words from the Keccak squeeze datapath, parses them into candidates, rejects out-of-range values and delivers accepted coefficients in order over a valid/ready stream. It stops after exactly KYBER_N coefficients. It replaces the single-candidate combinational comparer in the matrix-generation path.

## Interface
- KYBER_N, 256, coefficients per polynomial
- KYBER_Q, 3329, modulus
- IN_BYTES, 8, bytes per input word (≥3); byte j = i_data[8j+7:8j]
- FIFO_DEPTH, 4, accepted-coefficient FIFO entries (power of 2, ≥4)
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset (one clock; synchronous, active-low is fixed)
- i_start  in  1  one-cycle pulse: begin a new polynomial
- i_valid  in  1  input word valid
- i_data  in  8·IN_BYTES  squeeze bytes
- o_ready  out  1  sampler accepts i_data this cycle
- o_valid  out  1  coefficient available
- o_coeff  out  12  coefficient, < KYBER_Q
- o_idx  out  $clog2(KYBER_N)  index of o_coeff
- i_ready  in  1  downstream takes o_coeff
- o_busy  out  1  polynomial in progress
- o_done  out  1  one-cycle pulse, last coefficient delivered
- i_legacy  in  1  legacy mode select (only with REJ_LEGACY_19Q_EN)

## Operation
- Byte buffer, capacity IN_BYTES+2, FIFO order; occupancy occ.
- o_ready = o_busy && occ<3 && count<KYBER_N. A handshake appends all IN_BYTES bytes, byte 0 first. No parse happens in a load cycle.
- Parse when occ≥3, at least 2 FIFO slots free, and count<KYBER_N. Consumes b0,b1,b2 and forms two candidates:
  - d1 = b0 | (b1[3:0]<<8)
  - d2 = b1[7:4] | (b2<<4)
  - A candidate is accepted iff < KYBER_Q.
- The parse result is registered with per-candidate flags, then written to the FIFO, d1 before d2.
- count (0..KYBER_N) increments per FIFO write.
  - At count==KYBER_N-1 with both candidates accepted, only d1 is written.
  - Once count==KYBER_N, all in-flight candidates and buffered bytes are discarded.
- Output: first-word-fall-through FIFO. o_idx is a counter advanced on each o_valid&&i_ready.
- Delivering index KYBER_N-1 produces:
  - o_done=1 for one cycle
  - o_busy=0 from the next cycle
- i_start at any time, including mid-polynomial, clears buffer, pipeline register, FIFO, count and o_idx, and sets o_busy=1 the next cycle. i_start has priority over simultaneous handshakes.
- Reset values: o_ready=0, o_valid=0, o_coeff=0, o_idx=0, o_busy=0, o_done=0; all internal state cleared.

## Timing
- Input handshake at edge k: parse at edge k+1, FIFO write at edge k+2, o_valid=1 after edge k+2 (latency 3 edges).
- Sustained rate: 2 candidates per cycle while occ≥3 and the FIFO has room. With the default parameters, an 8-byte word yields 2 parse cycles and 2 leftover bytes.
- Back-pressure: the FIFO-free check counts the pending pipeline entry, so there is no overflow with i_ready=0 indefinitely.
- Handshake/coefficient transfers on edges where valid&&ready, standard AXI-stream semantics. o_valid, o_coeff and o_idx hold stable until accepted.

## Configuration
- REJ_LEGACY_19Q_EN defined: adds port i_legacy. Sampling i_legacy=1 at i_start selects legacy mode:
  - Parse consumes 2 bytes, forming one candidate c={b1,b0}.
  - c is accepted iff c < 19·KYBER_Q = 63251.
  - Output is c mod KYBER_Q: Barrett step t=(c·20159)>>26, r=c−t·KYBER_Q, one conditional subtract. Same latency.
  - Parse requires occ≥2; o_ready requires occ<2.
- Undefined: no i_legacy port; 12-bit mode only.

## Structure
- Shared package kyber_pkg:
  - KYBER_Q, KYBER_N
  - REJ_CMP_19Q=63251
  - BARRETT_M=20159, BARRETT_SH=26
- Sub-module kyber_coeff_fifo: synchronous FWFT FIFO, 2-write/1-read, reports free slots, synchronous clear.

## Test plan
- Reset, then start; bytes 00 0D 00 00 00 00 00 00 → coefficients 3328 (idx0), 0 (idx1), 0, 0; o_valid first high 3 edges after handshake.
- Bytes 01 0D FF (d1=3329, d2=4080) → both rejected, no FIFO write, count unchanged.
- Random SHAKE stream vs. software reference, random i_ready stalls → exactly 256 coefficients, identical sequence, o_done single pulse, o_busy falls next cycle, no further o_ready.
- count=255 with group yielding two accepted candidates → only d1 delivered at idx255, d2 and leftover bytes dropped.
- i_start at idx 100 with FIFO full and i_ready=0 → FIFO emptied, o_idx=0, next coefficient comes from new data only; rst_n low mid-run → all outputs 0 next edge.
- REJ_LEGACY_19Q_EN, i_legacy=1: bytes 12 F7 → 3328; bytes 13 F7 (63251) → rejected; bytes 01 0D → 0.

Source files
------------

// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants and Barrett reduction helper
// Contents: KYBER_N, KYBER_Q, REJ_CMP_19Q, BARRETT_M, BARRETT_SH,
//           barrett_reduce() (16-bit candidate -> value mod KYBER_Q)
package kyber_pkg;

    localparam int KYBER_N     = 256;
    localparam int KYBER_Q     = 3329;
    localparam int REJ_CMP_19Q = 63251;
    localparam int BARRETT_M   = 20159;
    localparam int BARRETT_SH  = 26;

    // One Barrett step plus a single conditional subtract; exact for c < 19*Q.
    function automatic logic [11:0] barrett_reduce(input logic [15:0] c);
        logic [31:0] t;
        logic [12:0] r;
        t = (32'(c) * 32'(BARRETT_M)) >> BARRETT_SH;
        r = 13'(32'(c) - t * 32'(KYBER_Q));
        if (r >= 13'(KYBER_Q)) begin
            r = r - 13'(KYBER_Q);
        end
        return r[11:0];
    endfunction

endpackage

// File: rtl/kyber_coeff_fifo.sv
// rtl/kyber_coeff_fifo.sv - synchronous first-word-fall-through coefficient FIFO, 2 writes / 1 read
// Ports: clk_i, rst_n_i (sync active-low), clr_i (sync clear),
//        wr_n_i (0..2 entries written this cycle), wr_d0_i (first), wr_d1_i (second),
//        rd_i (pop head), rd_data_o (head entry), empty_o, free_o (free slots)
module kyber_coeff_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic [1:0]    wr_n_i,
    input  logic [W-1:0]  wr_d0_i,
    input  logic [W-1:0]  wr_d1_i,
    input  logic          rd_i,
    output logic [W-1:0]  rd_data_o,
    output logic          empty_o,
    output logic [AW:0]   free_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          rd_en;

    assign rd_en     = rd_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (cnt_q == '0);
    assign free_o    = (AW+1)'(DEPTH) - cnt_q;

    // The caller never writes more entries than free_o reports.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_n_i != 2'd0) begin
                mem_q[wr_ptr_q] <= wr_d0_i;
            end
            if (wr_n_i == 2'd2) begin
                mem_q[wr_ptr_q + AW'(1)] <= wr_d1_i;
            end
            wr_ptr_q <= wr_ptr_q + AW'(wr_n_i);
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + (AW+1)'(wr_n_i) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/kyber_rej_uniform_sampler.sv
// rtl/kyber_rej_uniform_sampler.sv - streaming rejection sampler, SHAKE128 bytes -> KYBER_N coefficients mod KYBER_Q
// Ports: clk, rst_n (sync active-low), i_start (new polynomial pulse),
//        i_valid/o_ready/i_data (input words, byte 0 first), o_valid/i_ready/o_coeff/o_idx
//        (coefficient stream), o_busy (polynomial in progress), o_done (last coefficient delivered),
//        i_legacy (only when REJ_LEGACY_19Q_EN is defined: 16-bit candidates, < 19*Q, reduced mod Q)
module kyber_rej_uniform_sampler
    import kyber_pkg::*;
#(
    parameter int IN_BYTES   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic                       i_valid,
    input  logic [8*IN_BYTES-1:0]      i_data,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [11:0]                o_coeff,
    output logic [$clog2(KYBER_N)-1:0] o_idx,
    input  logic                       i_ready,
    output logic                       o_busy,
    output logic                       o_done
`ifdef REJ_LEGACY_19Q_EN
    ,
    input  logic                       i_legacy
`endif
);

    localparam int CAP    = IN_BYTES + 2;
    localparam int BW     = 8 * CAP;
    localparam int OCC_W  = $clog2(CAP + 1);
    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W  = $clog2(KYBER_N + 1);
    localparam int IDX_W  = $clog2(KYBER_N);

    // Byte buffer: byte 0 (oldest) in bits [7:0]; bytes above occ are kept zero.
    logic [BW-1:0]    buf_q, buf_d;
    logic [OCC_W-1:0] occ_q, occ_d, need;
    logic             busy_q, done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             pipe_vld_q;
    logic [1:0]       pipe_acc_q;
    logic [11:0]      pipe_c0_q, pipe_c1_q;
    logic             legacy;

    logic [7:0]       b0, b1, b2;
    logic [11:0]      par_c0, par_c1;
    logic [1:0]       par_acc;
    logic [1:0]       wr_n;
    logic [11:0]      wr_d0;
    logic [11:0]      fifo_data;
    logic             fifo_empty;
    logic [FREE_W-1:0] fifo_free;
    logic             cnt_full, load, parse, rd;

`ifdef REJ_LEGACY_19Q_EN
    logic legacy_q;
    assign legacy = legacy_q;
`else
    assign legacy = 1'b0;
`endif

    assign need     = legacy ? OCC_W'(2) : OCC_W'(3);
    assign cnt_full = (cnt_q == CNT_W'(KYBER_N));
    assign o_ready  = busy_q && (occ_q < need) && !cnt_full;
    assign load     = i_valid && o_ready;
    // Free-slot check reserves room for what the pipeline register writes this cycle.
    assign parse    = busy_q && (occ_q >= need) && !cnt_full
                      && (int'(fifo_free) >= int'(wr_n) + 2);

    assign b0 = buf_q[7:0];
    assign b1 = buf_q[15:8];
    assign b2 = buf_q[23:16];

    always_comb begin
        par_c0  = {b1[3:0], b0};
        par_c1  = {b2, b1[7:4]};
        par_acc = {par_c1 < 12'(KYBER_Q), par_c0 < 12'(KYBER_Q)};
`ifdef REJ_LEGACY_19Q_EN
        if (legacy) begin
            par_c0  = barrett_reduce({b1, b0});
            par_c1  = '0;
            par_acc = {1'b0, {b1, b0} < 16'(REJ_CMP_19Q)};
        end
`endif
    end

    // Entries committed from the pipeline register; the final slot takes only d1.
    always_comb begin
        wr_n = 2'd0;
        if (pipe_vld_q && !cnt_full) begin
            if (pipe_acc_q == 2'b11) begin
                wr_n = (cnt_q == CNT_W'(KYBER_N - 1)) ? 2'd1 : 2'd2;
            end else if (pipe_acc_q != 2'b00) begin
                wr_n = 2'd1;
            end
        end
    end
    assign wr_d0 = pipe_acc_q[0] ? pipe_c0_q : pipe_c1_q;

    always_comb begin
        buf_d = buf_q;
        occ_d = occ_q;
        if (cnt_full) begin
            buf_d = '0;
            occ_d = '0;
        end else if (load) begin
            buf_d = buf_q | ({16'h0000, i_data} << {occ_q, 3'b000});
            occ_d = occ_q + OCC_W'(IN_BYTES);
        end else if (parse) begin
            buf_d = buf_q >> {need, 3'b000};
            occ_d = occ_q - need;
        end
    end

    assign o_valid = !fifo_empty;
    assign o_coeff = o_valid ? fifo_data : 12'd0;
    assign o_idx   = idx_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign rd      = o_valid && i_ready;

    kyber_coeff_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (12)
    ) u_fifo (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .clr_i     (i_start),
        .wr_n_i    (wr_n),
        .wr_d0_i   (wr_d0),
        .wr_d1_i   (pipe_c1_q),
        .rd_i      (rd),
        .rd_data_o (fifo_data),
        .empty_o   (fifo_empty),
        .free_o    (fifo_free)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q      <= '0;
            occ_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            pipe_vld_q <= 1'b0;
            pipe_acc_q <= 2'b00;
            pipe_c0_q  <= '0;
            pipe_c1_q  <= '0;
`ifdef REJ_LEGACY_19Q_EN
            legacy_q   <= 1'b0;
`endif
        end else if (i_start) begin
            buf_q      <= '0;
            occ_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            pipe_vld_q <= 1'b0;
            pipe_acc_q <= 2'b00;
            pipe_c0_q  <= '0;
            pipe_c1_q  <= '0;
`ifdef REJ_LEGACY_19Q_EN
            legacy_q   <= i_legacy;
`endif
        end else begin
            buf_q      <= buf_d;
            occ_q      <= occ_d;
            pipe_vld_q <= parse;
            pipe_acc_q <= parse ? par_acc : 2'b00;
            pipe_c0_q  <= par_c0;
            pipe_c1_q  <= par_c1;
            cnt_q      <= cnt_q + CNT_W'(wr_n);
            done_q     <= 1'b0;
            if (rd) begin
                idx_q <= idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(KYBER_N - 1)) begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            end
        end
    end

endmodule
